// File: rtl/ucsbece154b_branch_resolve_if.sv
// ucsbece154b_branch_resolve_if
//   Bundle between the pipeline/predictor and the execute-stage branch resolver.
//   Fetch side : pcF_i, BranchTakenF_i, BTBtargetF_i, PHTreadaddressF_i
//   Hazards    : StallD_i, FlushD_i, FlushE_i
//   Execute    : opE_i, BranchCondE_i, PCTargetE_i, PCPlus4E_i
//   Updates    : BTB write port, PHT write port, GHRreset_o, Mispredict_o/PCcorrect_o
//   Statistics : BranchCount_o, MispredCount_o
//   Modports   : slave  = the resolver (consumes pipeline info, drives updates)
//                master = the surrounding pipeline / predictor
interface ucsbece154b_branch_resolve_if #(
    parameter int NUM_BTB_ENTRIES = 32,
    parameter int NUM_GHR_BITS    = 5
);
    localparam int IDXW = $clog2(NUM_BTB_ENTRIES);

    logic [31:0]             pcF_i;
    logic                    BranchTakenF_i;
    logic [31:0]             BTBtargetF_i;
    logic [NUM_GHR_BITS-1:0] PHTreadaddressF_i;
    logic                    StallD_i;
    logic                    FlushD_i;
    logic                    FlushE_i;
    logic [6:0]              opE_i;
    logic                    BranchCondE_i;
    logic [31:0]             PCTargetE_i;
    logic [31:0]             PCPlus4E_i;

    logic [IDXW-1:0]         BTBwriteaddress_o;
    logic [65:0]             BTBwritedata_o;
    logic                    BTB_we_o;
    logic                    PHTwe_o;
    logic                    PHTincrement_o;
    logic [NUM_GHR_BITS-1:0] PHTwriteaddress_o;
    logic                    GHRreset_o;
    logic                    Mispredict_o;
    logic [31:0]             PCcorrect_o;
    logic [31:0]             BranchCount_o;
    logic [31:0]             MispredCount_o;

    modport slave (
        input  pcF_i, BranchTakenF_i, BTBtargetF_i, PHTreadaddressF_i,
        input  StallD_i, FlushD_i, FlushE_i,
        input  opE_i, BranchCondE_i, PCTargetE_i, PCPlus4E_i,
        output BTBwriteaddress_o, BTBwritedata_o, BTB_we_o,
        output PHTwe_o, PHTincrement_o, PHTwriteaddress_o,
        output GHRreset_o, Mispredict_o, PCcorrect_o,
        output BranchCount_o, MispredCount_o
    );

    modport master (
        output pcF_i, BranchTakenF_i, BTBtargetF_i, PHTreadaddressF_i,
        output StallD_i, FlushD_i, FlushE_i,
        output opE_i, BranchCondE_i, PCTargetE_i, PCPlus4E_i,
        input  BTBwriteaddress_o, BTBwritedata_o, BTB_we_o,
        input  PHTwe_o, PHTincrement_o, PHTwriteaddress_o,
        input  GHRreset_o, Mispredict_o, PCcorrect_o,
        input  BranchCount_o, MispredCount_o
    );
endinterface

// File: rtl/ucsbece154b_branch_resolve.sv
// ucsbece154b_branch_resolve
//   Execute-stage branch resolver and update source for the BTB/gshare predictor.
//   Carries fetch-time prediction metadata through D and E, compares it with
//   the actual outcome in E, and drives BTB/PHT/GHR updates, the PC redirect,
//   and branch/mispredict statistics.
//   Ports:
//     clk      clock, all state updates on the rising edge
//     reset_i  synchronous active-high reset
//     bus      ucsbece154b_branch_resolve_if.slave (fetch, hazard, execute, update signals)
module ucsbece154b_branch_resolve #(
    parameter int NUM_BTB_ENTRIES = 32,
    parameter int NUM_GHR_BITS    = 5
) (
    input  logic                          clk,
    input  logic                          reset_i,
    ucsbece154b_branch_resolve_if.slave   bus
);
    localparam int IDXW = $clog2(NUM_BTB_ENTRIES);

    localparam logic [6:0] INSTR_BRANCH_OP = 7'b1100011;
    localparam logic [6:0] INSTR_JAL_OP    = 7'b1101111;
    localparam logic [6:0] INSTR_JALR_OP   = 7'b1100111;

    // pc[1:0] is never needed (instructions are word aligned), so only the word address is carried.
    typedef struct packed {
        logic                    v;
        logic [31:2]             pc_w;
        logic                    pred_t;
        logic [31:0]             pred_tgt;
        logic [NUM_GHR_BITS-1:0] pht_idx;
    } meta_t;

    meta_t       meta_d;
    meta_t       meta_e;
    logic [31:0] branch_count;
    logic [31:0] mispred_count;

    logic is_b;
    logic is_j;
    logic ctl;
    logic act_t;
    logic mis;

    always_ff @(posedge clk) begin
        if (reset_i) begin
            meta_d        <= '0;
            meta_e        <= '0;
            branch_count  <= '0;
            mispred_count <= '0;
        end else begin
            // Flush outranks stall; the whole record is zeroed so bubbles stay deterministic.
            if (bus.FlushD_i) begin
                meta_d <= '0;
            end else if (!bus.StallD_i) begin
                meta_d <= '{v:        1'b1,
                            pc_w:     bus.pcF_i[31:2],
                            pred_t:   bus.BranchTakenF_i,
                            pred_tgt: bus.BTBtargetF_i,
                            pht_idx:  bus.PHTreadaddressF_i};
            end

            if (bus.FlushE_i) begin
                meta_e <= '0;
            end else begin
                meta_e <= meta_d;
            end

            // An instruction being flushed out of E at this edge is not counted.
            if (ctl && !bus.FlushE_i) begin
                branch_count <= branch_count + 32'd1;
            end
            if (mis && !bus.FlushE_i) begin
                mispred_count <= mispred_count + 32'd1;
            end
        end
    end

    always_comb begin
        is_b  = (bus.opE_i == INSTR_BRANCH_OP);
        is_j  = (bus.opE_i == INSTR_JAL_OP) || (bus.opE_i == INSTR_JALR_OP);
        ctl   = meta_e.v && (is_b || is_j);
        act_t = is_j ? 1'b1 : bus.BranchCondE_i;
        // A predicted-taken non-control op is deliberately not flagged: ctl gates it off.
        mis   = ctl && ((meta_e.pred_t != act_t) ||
                        (act_t && (meta_e.pred_tgt != bus.PCTargetE_i)));
    end

    assign bus.Mispredict_o      = mis;
    assign bus.GHRreset_o        = mis;
    assign bus.PCcorrect_o       = act_t ? bus.PCTargetE_i : bus.PCPlus4E_i;

    assign bus.PHTwe_o           = meta_e.v && is_b;
    assign bus.PHTincrement_o    = act_t;
    assign bus.PHTwriteaddress_o = meta_e.pht_idx;

    assign bus.BTB_we_o          = ctl && act_t;
    assign bus.BTBwriteaddress_o = meta_e.pc_w[IDXW+1:2];
    assign bus.BTBwritedata_o    = {is_b, is_j,
                                    {(IDXW+2){1'b0}}, meta_e.pc_w[31:IDXW+2],
                                    bus.PCTargetE_i};

    assign bus.BranchCount_o     = branch_count;
    assign bus.MispredCount_o    = mispred_count;
endmodule

// File: tb/tb_ucsbece154b_branch_resolve.sv
module tb_ucsbece154b_branch_resolve;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_NOP = 7'b0010011;
    localparam logic [6:0] OP_ALU = 7'b0110011;

    logic clk;
    logic reset_i;
    int   n_cmp;
    int   n_err;

    ucsbece154b_branch_resolve_if #(.NUM_BTB_ENTRIES(32), .NUM_GHR_BITS(5)) bus ();

    ucsbece154b_branch_resolve #(.NUM_BTB_ENTRIES(32), .NUM_GHR_BITS(5)) dut (
        .clk     (clk),
        .reset_i (reset_i),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fetch(input logic [31:0] pc, input logic pt, input logic [31:0] tgt,
                         input logic [4:0] idx);
        bus.pcF_i             = pc;
        bus.BranchTakenF_i    = pt;
        bus.BTBtargetF_i      = tgt;
        bus.PHTreadaddressF_i = idx;
    endtask

    task automatic exec(input logic [6:0] op, input logic cond, input logic [31:0] tgt,
                        input logic [31:0] p4);
        bus.opE_i         = op;
        bus.BranchCondE_i = cond;
        bus.PCTargetE_i   = tgt;
        bus.PCPlus4E_i    = p4;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset_i = 1'b1;
        fetch(32'h0, 1'b0, 32'h0, 5'h0);
        exec(OP_NOP, 1'b0, 32'h0, 32'h0);
        bus.StallD_i = 1'b0;
        bus.FlushD_i = 1'b0;
        bus.FlushE_i = 1'b0;

        // 1: reset
        repeat (3) tick();
        reset_i = 1'b0;
        #1;
        chk("rst_btb_we",   66'(bus.BTB_we_o), 66'h0);
        chk("rst_pht_we",   66'(bus.PHTwe_o), 66'h0);
        chk("rst_mis",      66'(bus.Mispredict_o), 66'h0);
        chk("rst_ghr",      66'(bus.GHRreset_o), 66'h0);
        chk("rst_bcnt",     66'(bus.BranchCount_o), 66'h0);
        chk("rst_mcnt",     66'(bus.MispredCount_o), 66'h0);
        chk("rst_btb_data", bus.BTBwritedata_o, 66'h0);
        chk("rst_pccorr",   66'(bus.PCcorrect_o), 66'h0);

        // 2: beq not-predicted but taken
        fetch(32'h104, 1'b0, 32'h0, 5'h0A);
        tick();
        fetch(32'h0, 1'b0, 32'h0, 5'h0);
        tick();
        exec(OP_BEQ, 1'b1, 32'h80, 32'h108);
        #1;
        chk("t2_mis",      66'(bus.Mispredict_o), 66'h1);
        chk("t2_ghr",      66'(bus.GHRreset_o), 66'h1);
        chk("t2_pccorr",   66'(bus.PCcorrect_o), 66'h80);
        chk("t2_btb_we",   66'(bus.BTB_we_o), 66'h1);
        chk("t2_btb_addr", 66'(bus.BTBwriteaddress_o), 66'h1);
        chk("t2_btb_data", bus.BTBwritedata_o, {1'b1, 1'b0, 32'h2, 32'h80});
        chk("t2_pht_we",   66'(bus.PHTwe_o), 66'h1);
        chk("t2_pht_inc",  66'(bus.PHTincrement_o), 66'h1);
        chk("t2_pht_addr", 66'(bus.PHTwriteaddress_o), 66'h0A);
        tick();
        exec(OP_NOP, 1'b0, 32'h0, 32'h0);
        #1;
        chk("t2_bcnt", 66'(bus.BranchCount_o), 66'h1);
        chk("t2_mcnt", 66'(bus.MispredCount_o), 66'h1);

        // 3: jal correctly predicted
        fetch(32'h200, 1'b1, 32'h300, 5'h03);
        tick();
        fetch(32'h0, 1'b0, 32'h0, 5'h0);
        tick();
        exec(OP_JAL, 1'b0, 32'h300, 32'h204);
        #1;
        chk("t3_mis",      66'(bus.Mispredict_o), 66'h0);
        chk("t3_btb_we",   66'(bus.BTB_we_o), 66'h1);
        chk("t3_btb_addr", 66'(bus.BTBwriteaddress_o), 66'h0);
        chk("t3_btb_data", bus.BTBwritedata_o, {1'b0, 1'b1, 32'h4, 32'h300});
        chk("t3_pht_we",   66'(bus.PHTwe_o), 66'h0);
        chk("t3_pccorr",   66'(bus.PCcorrect_o), 66'h300);
        tick();
        exec(OP_NOP, 1'b0, 32'h0, 32'h0);
        #1;
        chk("t3_bcnt", 66'(bus.BranchCount_o), 66'h2);
        chk("t3_mcnt", 66'(bus.MispredCount_o), 66'h1);

        // 4: beq predicted taken but falls through
        fetch(32'h104, 1'b1, 32'h500, 5'h11);
        tick();
        fetch(32'h0, 1'b0, 32'h0, 5'h0);
        tick();
        exec(OP_BEQ, 1'b0, 32'h500, 32'h108);
        #1;
        chk("t4_mis",      66'(bus.Mispredict_o), 66'h1);
        chk("t4_pccorr",   66'(bus.PCcorrect_o), 66'h108);
        chk("t4_pht_we",   66'(bus.PHTwe_o), 66'h1);
        chk("t4_pht_inc",  66'(bus.PHTincrement_o), 66'h0);
        chk("t4_pht_addr", 66'(bus.PHTwriteaddress_o), 66'h11);
        chk("t4_btb_we",   66'(bus.BTB_we_o), 66'h0);
        tick();
        exec(OP_NOP, 1'b0, 32'h0, 32'h0);
        #1;
        chk("t4_bcnt", 66'(bus.BranchCount_o), 66'h3);
        chk("t4_mcnt", 66'(bus.MispredCount_o), 66'h2);

        // non-control op carrying a stale taken prediction
        fetch(32'h10, 1'b1, 32'h40, 5'h05);
        tick();
        fetch(32'h0, 1'b0, 32'h0, 5'h0);
        tick();
        exec(OP_ALU, 1'b1, 32'h99, 32'h14);
        #1;
        chk("alu_mis",    66'(bus.Mispredict_o), 66'h0);
        chk("alu_btb_we", 66'(bus.BTB_we_o), 66'h0);
        chk("alu_pht_we", 66'(bus.PHTwe_o), 66'h0);
        tick();
        exec(OP_NOP, 1'b0, 32'h0, 32'h0);
        #1;
        chk("alu_bcnt", 66'(bus.BranchCount_o), 66'h3);
        chk("alu_mcnt", 66'(bus.MispredCount_o), 66'h2);

        // 5: stall D twice, then flush+stall together
        fetch(32'h404, 1'b1, 32'h600, 5'h07);
        tick();
        bus.StallD_i = 1'b1;
        fetch(32'h800, 1'b0, 32'h0, 5'h1F);
        for (int i = 0; i < 2; i++) begin
            tick();
            exec(OP_BEQ, 1'b1, 32'h600, 32'h408);
            #1;
            chk("t5_hold_pht_addr", 66'(bus.PHTwriteaddress_o), 66'h07);
            chk("t5_hold_btb_addr", 66'(bus.BTBwriteaddress_o), 66'h1);
            chk("t5_hold_mis",      66'(bus.Mispredict_o), 66'h0);
            exec(OP_NOP, 1'b0, 32'h0, 32'h0);
        end
        bus.FlushD_i = 1'b1;
        tick();
        exec(OP_BEQ, 1'b1, 32'h600, 32'h408);
        #1;
        chk("t5_last_held", 66'(bus.PHTwriteaddress_o), 66'h07);
        exec(OP_NOP, 1'b0, 32'h0, 32'h0);
        bus.FlushD_i = 1'b0;
        bus.StallD_i = 1'b0;
        tick();
        exec(OP_BEQ, 1'b1, 32'h600, 32'h408);
        #1;
        chk("t5_bubble_pht_we", 66'(bus.PHTwe_o), 66'h0);
        chk("t5_bubble_btb_we", 66'(bus.BTB_we_o), 66'h0);
        chk("t5_bubble_mis",    66'(bus.Mispredict_o), 66'h0);
        tick();
        exec(OP_NOP, 1'b0, 32'h0, 32'h0);
        #1;
        chk("t5_bcnt", 66'(bus.BranchCount_o), 66'h3);

        // FlushE on a valid branch: not counted, E becomes a bubble
        exec(OP_BEQ, 1'b1, 32'h0, 32'h804);
        #1;
        chk("fe_pre_mis", 66'(bus.Mispredict_o), 66'h1);
        bus.FlushE_i = 1'b1;
        tick();
        bus.FlushE_i = 1'b0;
        #1;
        chk("fe_bcnt",   66'(bus.BranchCount_o), 66'h3);
        chk("fe_mcnt",   66'(bus.MispredCount_o), 66'h2);
        chk("fe_pht_we", 66'(bus.PHTwe_o), 66'h0);
        exec(OP_NOP, 1'b0, 32'h0, 32'h0);

        // 6: reset while a mispredicting branch sits in E
        fetch(32'h104, 1'b0, 32'h0, 5'h0A);
        tick();
        fetch(32'h0, 1'b0, 32'h0, 5'h0);
        tick();
        exec(OP_BEQ, 1'b1, 32'h80, 32'h108);
        #1;
        chk("t6_pre_mis", 66'(bus.Mispredict_o), 66'h1);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        #1;
        chk("t6_bcnt",   66'(bus.BranchCount_o), 66'h0);
        chk("t6_mcnt",   66'(bus.MispredCount_o), 66'h0);
        chk("t6_mis",    66'(bus.Mispredict_o), 66'h0);
        chk("t6_btb_we", 66'(bus.BTB_we_o), 66'h0);
        chk("t6_pht_we", 66'(bus.PHTwe_o), 66'h0);
        tick();
        #1;
        chk("t6_next_mis",    66'(bus.Mispredict_o), 66'h0);
        chk("t6_next_btb_we", 66'(bus.BTB_we_o), 66'h0);
        chk("t6_next_pht_we", 66'(bus.PHTwe_o), 66'h0);
        chk("t6_next_bcnt",   66'(bus.BranchCount_o), 66'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
